// File: rtl/wb_axi_writer_pkg.sv
// Shared definitions for the write-buffer to AXI line writer: FSM encoding,
// AXI burst constants and a line-word select helper.
package wb_axi_writer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StData = 3'd2,
    StResp = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [7:0] LEN_8BEAT  = 8'd7;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [2:0] LAST_BEAT  = 3'd7;
  localparam int unsigned LINE_W    = 256;

  // Word idx of a 256-bit line, word0 in bits [31:0].
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [2:0] idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/wb_axi_writer.sv
// Retires one 32-byte write-buffer line as a single 8-beat INCR AXI write
// burst. One transaction at a time; address phase fully precedes data phase.
module wb_axi_writer
  import wb_axi_writer_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned AW_ID    = 0
) (
  input  logic                clk,
  input  logic                rst,
  // write-buffer side
  input  logic                wen_i,
  input  logic [31:0]         waddr_i,
  input  logic [255:0]        wdata_i,
  output logic                done_o,
  output logic                busy_o,
  output logic                err_o,
  // AXI write address
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [ID_WIDTH-1:0] AwIdVal = ID_WIDTH'(AW_ID);

  state_e         state_q, state_d;
  logic [31:0]    addr_q;
  logic [255:0]   line_q;
  logic [2:0]     beat_q;
  logic           err_q;

  // Only one ID is ever outstanding, so the response ID carries no information.
  logic unused_bid;
  assign unused_bid = ^bid;

  // State register; reset abandons any in-flight burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (wen_i) state_d = StAddr;
      StAddr: if (awready) state_d = StData;
      StData: if (wready && (beat_q == LAST_BEAT)) state_d = StResp;
      StResp: if (bvalid) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Line capture, beat counter and sticky response error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == StIdle) && wen_i) begin
        addr_q <= waddr_i;
        line_q <= wdata_i;
      end
      // 3-bit counter wraps back to 0 on the wlast handshake.
      if ((state_q == StData) && wready) begin
        beat_q <= beat_q + 3'd1;
      end
      if ((state_q == StResp) && bvalid && (bresp != RESP_OKAY)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    wstrb   = 4'h0;
    bready  = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != StIdle);
    wdata   = line_word(line_q, beat_q);
    unique case (state_q)
      StIdle: ;
      StAddr: awvalid = 1'b1;
      StData: begin
        wvalid = 1'b1;
        wstrb  = 4'hF;
        wlast  = (beat_q == LAST_BEAT);
      end
      StResp: bready = 1'b1;
      StDone: done_o = 1'b1;
      default: ;
    endcase
  end

  assign awid    = AwIdVal;
  assign awaddr  = addr_q;
  assign awlen   = LEN_8BEAT;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign err_o   = err_q;

endmodule
